// File: rtl/seq_div_pkg.sv
// Shared encodings and sizing helpers for the sequential restoring divider.
// Latency: none (declarations only).
// Backpressure: not applicable.
package seq_div_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The counter must hold 0..WIDTH so the final iteration index is representable.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_sub_stage.sv
// Ripple subtractor a - b = a + ~b + 1 built from full-adder cells; bit WIDTH is the sign.
// Latency: combinational, one ripple through WIDTH+1 cells.
// Backpressure: none.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module sub_stage
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_b,
    output logic [WIDTH:0] o_diff
);
    logic [WIDTH:0] w_carry;
    logic [WIDTH:0] w_b_inv;

    assign w_b_inv    = ~i_b;
    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        full_adder u_fa (
            .i_a   (i_a[g]),
            .i_b   (w_b_inv[g]),
            .i_cin (w_carry[g]),
            .o_sum (o_diff[g]),
            .o_cout(w_carry[g+1])
        );
    end

    // The sign bit needs only the sum; its carry-out would be discarded anyway.
    assign o_diff[WIDTH] = i_a[WIDTH] ^ w_b_inv[WIDTH] ^ w_carry[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; SEQ_DIVIDER_ZERO_DETECT_EN short-cuts divide-by-zero.
// Latency: done WIDTH edges after the accepting edge (one edge for a detected zero divisor).
// Backpressure: start is accepted only in IDLE; starts while busy or done are dropped, never queued.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remd;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_take;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_last;

    // The dividend is shifted out of Q into R as quotient bits shift in behind it.
    assign w_shift = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};

    sub_stage #(.WIDTH(WIDTH)) u_sub (
        .i_a   (w_shift),
        .i_b   ({1'b0, r_div}),
        .o_diff(w_diff)
    );

    assign w_take     = ~w_diff[WIDTH];
    assign w_rem_next = w_take ? w_diff : w_shift;
    assign w_q_next   = {r_q[WIDTH-2:0], w_take};
    assign w_last     = (r_cnt == LAST_ITER);

`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
    logic r_dbz;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_q     <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_remd  <= '0;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
            r_dbz   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_div <= divisor;
                        r_q   <= dividend;
                        r_rem <= '0;
                        r_cnt <= '0;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
                        if (divisor == '0) begin
                            r_state <= DONE;
                            r_quot  <= '1;
                            r_remd  <= dividend;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_dbz   <= 1'b0;
                        end
`else
                        r_state <= RUN;
`endif
                    end
                end
                RUN: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    // Results load with the final iteration so they are valid in the done cycle.
                    if (w_last) begin
                        r_state <= DONE;
                        r_quot  <= w_q_next;
                        r_remd  <= w_rem_next[WIDTH-1:0];
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign quotient  = r_quot;
    assign remainder = r_remd;

`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
    assign div_by_zero = r_dbz & done;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: table vectors, multi-cycle corner sequences, random vs arithmetic model.
module tb_seq_divider;
    localparam int W = 4;
`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int vectors     = 0;
    int miscompares = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_q(input int a, input int b);
        return (b == 0) ? (1 << W) - 1 : a / b;
    endfunction

    function automatic int model_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    // Issues one start, waits for done, then confirms done lasted a single cycle.
    task automatic do_div(input int a, input int b, output int q, output int r,
                          output int dbz, output int lat, output int bcnt);
        int n;
        @(negedge clk);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clk); #1;
        start = 1'b0;
        n     = 0;
        bcnt  = 0;
        while (!done && n < 50) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
        check("busy_low_with_done", int'(busy), 0);
        lat = n + 1;
        q   = int'(quotient);
        r   = int'(remainder);
        dbz = int'(div_by_zero);
        @(posedge clk); #1;
        check("done_one_cycle", int'(done), 0);
    endtask

    task automatic run_and_check(input string name, input int a, input int b,
                                 input int eq, input int er);
        int q, r, dbz, lat, bcnt;
        bit zd_path;
        zd_path = ZD && (b == 0);
        do_div(a, b, q, r, dbz, lat, bcnt);
        $display("%s: %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", name, a, b, q, r, dbz, lat);
        check({name, "_q"}, q, eq);
        check({name, "_r"}, r, er);
        check({name, "_dbz"}, dbz, int'(zd_path));
        check({name, "_latency"}, lat, zd_path ? 1 : W + 1);
        check({name, "_busy_cycles"}, bcnt, zd_path ? 0 : W);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int n, q, r, dbz, lat, bcnt, a, b;
        bit seen_done;

        tbl[0] = '{13, 4, 3, 1};
        tbl[1] = '{15, 1, 15, 0};
        tbl[2] = '{7, 9, 0, 7};
        tbl[3] = '{0, 5, 0, 0};
        tbl[4] = '{11, 0, 15, 11};
        tbl[5] = '{9, 2, 4, 1};
        tbl[6] = '{14, 3, 4, 2};
        tbl[7] = '{15, 15, 1, 0};

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_quotient", int'(quotient), 0);
        check("reset_remainder", int'(remainder), 0);
        check("reset_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_and_check("table", tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r);

        // start held high through RUN while operands churn: only 9/2 may be used.
        @(negedge clk);
        start = 1'b1; dividend = 4'd9; divisor = 4'd2;
        @(posedge clk); #1;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            dividend = W'($urandom_range(0, 15));
            divisor  = W'($urandom_range(0, 15));
            @(posedge clk); #1;
            n++;
        end
        check("held_latency", n + 1, W + 1);
        check("held_q", int'(quotient), 4);
        check("held_r", int'(remainder), 1);
        @(negedge clk);
        dividend = 4'd14; divisor = 4'd3;
        @(posedge clk); #1;
        check("held_idle_busy", int'(busy), 0);
        check("held_idle_done", int'(done), 0);
        @(posedge clk); #1;
        check("held_reaccept_busy", int'(busy), 1);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_latency", n + 1, W + 1);
        check("b2b_q", int'(quotient), 4);
        check("b2b_r", int'(remainder), 2);
        @(posedge clk); #1;

        // Reset during the second RUN cycle aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_q", int'(quotient), 0);
        check("abort_r", int'(remainder), 0);
        check("abort_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("abort_no_done", int'(seen_done), 0);
        run_and_check("after_abort", 6, 3, 2, 0);

        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            do_div(a, b, q, r, dbz, lat, bcnt);
            check("rand_q", q, model_q(a, b));
            check("rand_r", r, model_r(a, b));
            check("rand_dbz", dbz, int'(ZD && b == 0));
            check("rand_latency", lat, (ZD && b == 0) ? 1 : W + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
